score_keeper: RTL and testbench

- Game-score bookkeeping stage for the bird-flying game. It sits directly upstream of DipScore.
- It counts pipes passed during a run, saturates the count, and keeps a session best score.
- It drives the 10-bit binary value that DipScore renders on the 7-segment display.
- After a crash, the displayed value alternates between the final score and the best score.

---
 rtl/bird_pkg.sv | 15 +
 rtl/pass_filter.sv | 42 ++++
 rtl/score_keeper.sv | 121 ++++++++++++
 tb/tb_score_keeper.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared definitions for the bird-game score path: score width, FSM encoding
// and the default saturation ceiling.
package bird_pkg;

  localparam int unsigned SCORE_W       = 10;
  localparam int unsigned MAX_SCORE_DEF = 999;

  // 2'b11 is not a legal state; the FSM recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

endpackage

// File: rtl/pass_filter.sv
// Rising-edge detect on a pipe-pass level plus a holdoff window that blocks
// re-crediting for HOLDOFF cycles after a pass has been accepted.
module pass_filter #(
  parameter int unsigned HOLDOFF = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic pass_i,
  input  logic load_i,
  input  logic clear_i,
  output logic credit_ok_o
);

  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic          pass_q;
  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (clear_i) begin
      hold_d = '0;
    end else if (load_i) begin
      hold_d = HW'(HOLDOFF);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
  end

  assign credit_ok_o = pass_i & ~pass_q & (hold_q == '0);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pass_q <= 1'b0;
      hold_q <= '0;
    end else begin
      pass_q <= pass_i;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Run score counter with saturation, session best tracking and the display
// value fed to DipScore (alternates final/best score after a crash).
module score_keeper
  import bird_pkg::*;
#(
  parameter int unsigned MAX_SCORE = MAX_SCORE_DEF,
  parameter int unsigned HOLDOFF   = 4,
  parameter int unsigned ALT_CYC   = 12_500_000
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               crash,
  input  logic               pipe_pass,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best,
  output logic [SCORE_W-1:0] disp_score,
  output logic [1:0]         state,
  output logic               new_best
);

  localparam int unsigned ALT_W = (ALT_CYC > 1) ? $clog2(ALT_CYC) : 1;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [SCORE_W-1:0] disp_q, disp_d;
  logic               nb_q, nb_d;
  logic [ALT_W-1:0]   alt_q, alt_d;
  logic               phase_q, phase_d;
  logic               credit_ok, hold_load, hold_clear;

  pass_filter #(.HOLDOFF(HOLDOFF)) u_pass_filter (
    .clk         (clk),
    .clr         (clr),
    .pass_i      (pipe_pass),
    .load_i      (hold_load),
    .clear_i     (hold_clear),
    .credit_ok_o (credit_ok)
  );

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    best_d     = best_q;
    disp_d     = disp_q;
    nb_d       = 1'b0;
    alt_d      = alt_q;
    phase_d    = phase_q;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        disp_d = best_q;
        if (start) begin
          state_d    = ST_RUN;
          score_d    = '0;
          hold_clear = 1'b1;
        end
      end
      ST_RUN: begin
        disp_d = score_q;
        if (crash) begin
          state_d = ST_OVER;
          alt_d   = '0;
          phase_d = 1'b0;
          if (score_q > best_q) begin
            best_d = score_q;
            nb_d   = 1'b1;
          end
        end else if (credit_ok) begin
          // Holdoff reloads even when the score is pinned at the ceiling.
          hold_load = 1'b1;
          if (score_q < SCORE_W'(MAX_SCORE)) score_d = score_q + SCORE_W'(1);
        end
      end
      ST_OVER: begin
        disp_d = phase_q ? best_q : score_q;
        if (start) begin
          state_d    = ST_RUN;
          score_d    = '0;
          hold_clear = 1'b1;
          alt_d      = '0;
        end else if (alt_q == ALT_W'(ALT_CYC - 1)) begin
          alt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          alt_d = alt_q + ALT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      best_q  <= '0;
      disp_q  <= '0;
      nb_q    <= 1'b0;
      alt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      best_q  <= best_d;
      disp_q  <= disp_d;
      nb_q    <= nb_d;
      alt_q   <= alt_d;
      phase_q <= phase_d;
    end
  end

  assign score      = score_q;
  assign best       = best_q;
  assign disp_score = disp_q;
  assign state      = state_q;
  assign new_best   = nb_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: per-cycle vector table plus
// hand-written sequences for holdoff, saturation, alternation and async reset.
module tb_score_keeper;

  localparam int MAXS = 999;

  logic       clk = 1'b0;
  logic       clr, start, crash, pipe_pass;
  logic [9:0] score, best, disp_score;
  logic [1:0] state;
  logic       new_best;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int m_score;

  typedef struct {
    bit st, cr, pp;
    int e_state, e_score, e_disp, e_best, e_nb;
  } vec_t;
  vec_t tbl[11];

  score_keeper #(.MAX_SCORE(999), .HOLDOFF(4), .ALT_CYC(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .crash      (crash),
    .pipe_pass  (pipe_pass),
    .score      (score),
    .best       (best),
    .disp_score (disp_score),
    .state      (state),
    .new_best   (new_best)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0; start = 1'b0; crash = 1'b0; pipe_pass = 1'b0;
    repeat (2) tick();
    clr = 1'b1;
    m_score = 0;
    chk("rst_state", state, 0);
    chk("rst_score", score, 0);
    chk("rst_best", best, 0);
    chk("rst_disp", disp_score, 0);
    chk("rst_nb", new_best, 0);
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
    m_score = 0;
    chk("start_state", state, 1);
    chk("start_score", score, 0);
  endtask

  // One pipe_pass pulse: hi cycles high then lo cycles low; score checked at the rise.
  task automatic pass_seq(input bit credited, input int hi, input int lo);
    pipe_pass = 1'b1;
    if (credited && m_score < MAXS) m_score++;
    exp_q.push_back(m_score);
    tick();
    chk("score_at_rise", score, exp_q.pop_front());
    if (hi > 1) begin
      tick();
      chk("disp_lag", disp_score, m_score);
      repeat (hi - 2) tick();
    end
    pipe_pass = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    // start crash pp | state score disp best nb
    tbl[0]  = '{1, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 1, 1, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 1, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, 2, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 2, 2, 2, 2, 1};
    tbl[8]  = '{1, 1, 0, 1, 0, 2, 2, 0};
    tbl[9]  = '{1, 1, 0, 2, 0, 0, 2, 0};
    tbl[10] = '{0, 0, 0, 2, 0, 0, 2, 0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].st; crash = tbl[i].cr; pipe_pass = tbl[i].pp;
      tick();
      chk($sformatf("tbl%0d_state", i), state, tbl[i].e_state);
      chk($sformatf("tbl%0d_score", i), score, tbl[i].e_score);
      chk($sformatf("tbl%0d_disp", i), disp_score, tbl[i].e_disp);
      chk($sformatf("tbl%0d_best", i), best, tbl[i].e_best);
      chk($sformatf("tbl%0d_nb", i), new_best, tbl[i].e_nb);
    end

    // Three long passes, then holdoff: rises 2 apart, then 6 apart from the credited one.
    do_reset();
    do_start();
    for (int i = 0; i < 3; i++) pass_seq(1'b1, 10, 10);
    chk("three_passes", score, 3);
    pass_seq(1'b1, 1, 1);
    pass_seq(1'b0, 1, 3);
    pass_seq(1'b1, 1, 4);
    chk("holdoff_total", score, 5);

    // Run to 7 and crash: best updates with a single-cycle pulse.
    do_reset();
    do_start();
    for (int i = 0; i < 7; i++) pass_seq(1'b1, 1, 4);
    crash = 1'b1; tick(); crash = 1'b0;
    chk("crash7_state", state, 2);
    chk("crash7_best", best, 7);
    chk("crash7_nb", new_best, 1);
    tick();
    chk("crash7_nb_drop", new_best, 0);
    crash = 1'b1; tick(); crash = 1'b0;
    chk("over_ignores_crash", state, 2);

    // Second run to 4: best kept, no pulse, display alternates 4/7 every 8 cycles.
    do_start();
    for (int i = 0; i < 4; i++) pass_seq(1'b1, 1, 4);
    crash = 1'b1; tick(); crash = 1'b0;
    chk("crash4_state", state, 2);
    chk("crash4_best", best, 7);
    chk("crash4_nb", new_best, 0);
    chk("crash4_disp", disp_score, 4);
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk($sformatf("alt_disp_k%0d", k), disp_score, (((k - 1) / 8) % 2 == 1) ? 7 : 4);
      chk("alt_nb", new_best, 0);
    end

    // Async reset between edges mid-run at score 5 clears best too.
    do_start();
    for (int i = 0; i < 5; i++) pass_seq(1'b1, 1, 4);
    chk("pre_clr_score", score, 5);
    #2 clr = 1'b0;
    #1;
    chk("aclr_state", state, 0);
    chk("aclr_score", score, 0);
    chk("aclr_best", best, 0);
    chk("aclr_disp", disp_score, 0);
    chk("aclr_nb", new_best, 0);
    clr = 1'b1;
    m_score = 0;
    tick();
    chk("post_clr_idle", state, 0);
    pipe_pass = 1'b1; tick(); pipe_pass = 1'b0;
    chk("idle_no_count", score, 0);
    chk("idle_state", state, 0);
    repeat (5) tick();

    // Crash together with a qualifying rise at score 2: no increment.
    do_start();
    for (int i = 0; i < 2; i++) pass_seq(1'b1, 1, 4);
    pipe_pass = 1'b1; crash = 1'b1; tick(); pipe_pass = 1'b0; crash = 1'b0;
    chk("crash_rise_state", state, 2);
    chk("crash_rise_score", score, 2);

    // Saturation at 999.
    do_reset();
    do_start();
    for (int i = 0; i < MAXS + 2; i++) pass_seq(1'b1, 1, 4);
    chk("sat_score", score, MAXS);
    chk("sat_state", state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
